// File: rtl/count_binary_button_pio.sv
// Push-button PIO with an Avalon-MM slave: synchronises the inputs, captures edges
// into sticky write-1-to-clear bits, and raises a level interrupt for unmasked captures.
module count_binary_button_pio #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q, d_q;
  logic [WIDTH-1:0] det_q, det_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       prime_q, prime_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] edge_raw, clr;
  logic             wr_en;
  logic             unused_wd;

  assign unused_wd = ^writedata;
  assign wr_en     = chipselect & ~write_n;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_raw = s2_q & ~d_q;
      2:       edge_raw = s2_q ^ d_q;
      default: edge_raw = ~s2_q & d_q;
    endcase
  end

  // Detection is suppressed until the synchroniser has been filled with real input levels.
  always_comb begin
    det_d   = (prime_q == 2'd3) ? edge_raw : '0;
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    mask_d  = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    clr     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_d   = (cap_q & ~clr) | det_q;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d[WIDTH-1:0] = s2_q;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = cap_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      d_q     <= '0;
      det_q   <= '0;
      prime_q <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
    end else begin
      s1_q    <= in_port;
      s2_q    <= s1_q;
      d_q     <= s2_q;
      det_q   <= det_d;
      prime_q <= prime_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_count_binary_button_pio.sv
// Directed bench: falling-edge instance plus an any-edge instance sharing the bus.
module tb_count_binary_button_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port, in_port2;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;
  logic [31:0] r1, r2;
  int          n_vec = 0;
  int          n_err = 0;

  count_binary_button_pio #(.WIDTH(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq));

  count_binary_button_pio #(.WIDTH(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs = 1'b1);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
    r1 = readdata;
    r2 = readdata2;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF; in_port2 = 4'h0;
    tick(3);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Inputs held high through reset release: priming suppresses the startup transition.
    rd(2'd3); chk("prime_cap", r1, 32'h0);
    chk("prime_irq", {31'b0, irq}, 32'h0);
    rd(2'd0); chk("data_F", r1, 32'hF);
    rd(2'd1); chk("reserved", r1, 32'h0);
    wr(2'd2, 32'h1, 1'b0);
    rd(2'd2); chk("mask_no_cs", r1, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1); chk("reserved_wr", r1, 32'h0);
    wr(2'd2, 32'hFFFF_FFF1);
    rd(2'd2); chk("mask_1", r1, 32'h1);

    // Bit 0 falls before edge N; capture and irq appear at N+3, not earlier.
    in_port = 4'hE;
    tick(3);
    chk("lat_n2_irq", {31'b0, irq}, 32'h0);
    tick();
    chk("lat_n3_irq", {31'b0, irq}, 32'h1);
    rd(2'd3); chk("cap_bit0", r1, 32'h1);
    wr(2'd3, 32'h1);
    chk("clr_irq", {31'b0, irq}, 32'h0);
    rd(2'd3); chk("clr_cap", r1, 32'h0);
    in_port = 4'hF;
    tick(4);
    rd(2'd3); chk("rise_ignored", r1, 32'h0);

    // Masked-off capture, then enabling the mask raises irq.
    wr(2'd2, 32'h0);
    in_port = 4'hB;
    tick(4);
    rd(2'd3); chk("cap_bit2", r1, 32'h4);
    chk("masked_irq", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h4);
    chk("unmask_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h4);
    in_port = 4'hF;
    tick(4);

    // Set wins over a simultaneous clear.
    in_port = 4'hD;
    tick(3);
    wr(2'd3, 32'h2);
    rd(2'd3); chk("set_wins", r1, 32'h2);
    wr(2'd3, 32'h2);
    rd(2'd3); chk("clr_after_set", r1, 32'h0);
    in_port = 4'hF;
    tick(4);

    // Data register follows the synchronised inputs.
    in_port = 4'hA;
    tick(3);
    rd(2'd0); chk("data_A", r1, 32'hA);
    rd(2'd1); chk("reserved_A", r1, 32'h0);
    rd(2'd3); chk("cap_5", r1, 32'h5);

    // Any-edge instance: one capture per toggle.
    wr(2'd3, 32'hF);
    in_port2 = 4'h8;
    tick(4);
    rd(2'd3); chk("any_rise", r2, 32'h8);
    wr(2'd3, 32'h8);
    rd(2'd3); chk("any_rise_once", r2, 32'h0);
    in_port2 = 4'h0;
    tick(4);
    rd(2'd3); chk("any_fall", r2, 32'h8);
    wr(2'd3, 32'h8);
    tick(3);
    rd(2'd3); chk("any_fall_once", r2, 32'h0);

    // Reset while irq is high clears everything asynchronously.
    in_port = 4'hF;
    tick(4);
    in_port = 4'hA;
    tick(4);
    wr(2'd2, 32'h4);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_irq", {31'b0, irq}, 32'h0);
    chk("async_readdata", readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    tick(6);
    rd(2'd3); chk("post_reset_cap", r1, 32'h0);
    rd(2'd2); chk("post_reset_mask", r1, 32'h0);

    // A capture in flight is dropped by reset.
    wr(2'd2, 32'hF);
    in_port = 4'h8;
    tick(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(6);
    rd(2'd3); chk("abort_cap", r1, 32'h0);
    chk("abort_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_binary_button_pio.md
COUNT_BINARY_BUTTON_PIO -- requirements
Module: count_binary_button_pio

Interface
REQ-001 Parameter WIDTH, default 4, is the number of input port bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 1, selects the captured edge: 0 = rising, 1 = falling, 2 = any.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port address, input, 2 bits: Avalon-MM slave register select.
REQ-006 Port chipselect, input, 1 bit: slave select; writes are qualified by it.
REQ-007 Port write_n, input, 1 bit: write strobe, active-low.
REQ-008 Port writedata, input, 32 bits: write data.
REQ-009 Port in_port, input, WIDTH bits: asynchronous external inputs (push-buttons).
REQ-010 Port readdata, output, 32 bits: registered read data.
REQ-011 Port irq, output, 1 bit: level interrupt request, active-high.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer (s1, s2), then into a delay register d; edge detection SHALL compare s2 against d.
REQ-013 Edge detection per bit: rising = s2 & ~d; falling = ~s2 & d; any = s2 ^ d, selected by EDGE_TYPE.
REQ-014 A 2-bit prime counter SHALL increment every clock after reset and saturate at 3; edge detection SHALL be masked to 0 while the counter is below 3, so no spurious edges are captured after reset.
REQ-015 edge_capture[WIDTH-1:0] bit SHALL set on the clock edge after its edge is detected and SHALL hold until cleared.
REQ-016 Register map: address 0 = data (read-only, s2); address 1 = reserved (reads 0, writes ignored); address 2 = irq_mask (read/write, WIDTH bits); address 3 = edge_capture (read, write-1-to-clear per bit).
REQ-017 A write SHALL occur when chipselect = 1 and write_n = 0; irq_mask SHALL load writedata[WIDTH-1:0]; an edge_capture write SHALL clear each bit where writedata is 1.
REQ-018 If an edge is detected on a bit in the same cycle as a clear of that bit, the set SHALL win and the bit SHALL remain 1.
REQ-019 readdata SHALL register, every clock, the zero-extended word selected by address (read latency 1, independent of chipselect); bits WIDTH..31 SHALL read 0.
REQ-020 irq SHALL equal the OR over all bits of (edge_capture & irq_mask), decoded combinationally from registers.
REQ-021 Latency: an in_port transition at input setup before clock edge N SHALL set edge_capture at edge N+3, and irq SHALL be high after edge N+3 if that bit is masked in.
REQ-022 A level change shorter than one clock period MAY be missed; a level held for 2 or more clocks SHALL be captured exactly once per qualifying edge.

Reset
REQ-023 When reset_n is low, s1, s2, d, the prime counter, edge_capture, irq_mask and readdata SHALL clear to 0, so irq = 0.
REQ-024 Reset asserted mid-operation SHALL abort pending captures immediately; after release, REQ-014 priming SHALL apply again.

Verification
REQ-025 WIDTH=4, EDGE_TYPE=1: in_port held at 4'hF through reset release -> edge_capture reads 0, irq = 0 (priming suppresses).
REQ-026 Write mask 4'h1, drive in_port[0] from 1 to 0 before edge N -> edge_capture = 4'h1 and irq = 1 after edge N+3; write 32'h1 to address 3 -> edge_capture = 0, irq = 0 on the next cycle.
REQ-027 Mask 4'h0, falling edge on bit 2 -> edge_capture = 4'h4 and irq stays 0; then write mask 4'h4 -> irq = 1 after that write edge.
REQ-028 Falling edge detected on bit 1 in the same cycle as a write of 32'h2 to address 3 -> edge_capture[1] = 1 afterwards.
REQ-029 in_port = 4'hA held stable, read address 0 -> readdata = 32'h0000000A one clock after address is presented; read address 1 -> 32'h0.
REQ-030 EDGE_TYPE=2, toggle bit 3 high then low, with each level held 4 clocks and a clear between toggles -> one capture per toggle; reset asserted while irq = 1 -> irq = 0 immediately and all registers read 0.
